block_plotter: RTL and testbench

// - Rasterises one game row: LEN adjacent SQ x SQ squares at a base (x,y) into single-pixel writes.
// - Sits downstream of the x/y/colour loader and upstream of the VGA adapter (plot/x/y/colour).
// - Draw and erase share one path: erase is simply colour_in = 3'b000 from the loader.

---
 rtl/block_pkg.sv | 38 +++
 rtl/square_scan_counter.sv | 51 +++++
 rtl/block_plotter.sv | 129 ++++++++++++
 tb/tb_block_plotter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/block_pkg.sv
`default_nettype none
// ============================================================================
// block_pkg : screen geometry, square size and FSM encoding for block_plotter
// Rev 1.0
// ============================================================================
package block_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int SQ_SIZE  = 4;
    localparam int MAX_LEN  = 4;

    localparam int PX_W = $clog2(MAX_LEN * SQ_SIZE);
    localparam int PY_W = $clog2(SQ_SIZE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } plot_state_t;

    function automatic logic [2:0] clamp_len(input logic [2:0] len);
        if (len == 3'd0) begin
            return 3'd1;
        end else if (int'(len) > MAX_LEN) begin
            return 3'(MAX_LEN);
        end else begin
            return len;
        end
    endfunction

    // Last px index of a row of 'len' squares (len already clamped to >= 1)
    function automatic logic [PX_W-1:0] px_limit(input logic [2:0] len);
        return PX_W'(int'(len) * SQ_SIZE - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/square_scan_counter.sv
`default_nettype none
// ============================================================================
// square_scan_counter : row-major px/py scan with programmable px limit
// Rev 1.0
// ============================================================================
module square_scan_counter #(
    parameter int PX_W    = 4,
    parameter int PY_W    = 2,
    parameter int PY_LAST = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic            en_i,
    input  logic [PX_W-1:0] px_lim_i,
    output logic [PX_W-1:0] px_o,
    output logic [PY_W-1:0] py_o,
    output logic            last_o
);

    logic [PX_W-1:0] px_q;
    logic [PY_W-1:0] py_q;
    logic            w_px_wrap;
    logic            w_py_wrap;

    assign w_px_wrap = (px_q == px_lim_i);
    assign w_py_wrap = (py_q == PY_W'(PY_LAST));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            px_q <= '0;
            py_q <= '0;
        end else if (load_i) begin
            px_q <= '0;
            py_q <= '0;
        end else if (en_i) begin
            if (w_px_wrap) begin
                px_q <= '0;
                py_q <= w_py_wrap ? '0 : py_q + 1'b1;
            end else begin
                px_q <= px_q + 1'b1;
            end
        end
    end

    assign px_o   = px_q;
    assign py_o   = py_q;
    assign last_o = w_px_wrap && w_py_wrap;

endmodule
`default_nettype wire

// File: rtl/block_plotter.sv
`default_nettype none
// ============================================================================
// block_plotter : rasterises a row of SQ_SIZE x SQ_SIZE squares into VGA writes
// Rev 1.0
// ============================================================================
module block_plotter
    import block_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [2:0] colour_in,
    input  logic [2:0] len_in,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    plot_state_t     state_q;
    logic [7:0]      bx_q;
    logic [6:0]      by_q;
    logic [2:0]      col_q;
    logic [PX_W-1:0] lim_q;

    logic [7:0]      vga_x_q;
    logic [6:0]      vga_y_q;
    logic [2:0]      vga_col_q;
    logic            plot_q;
    logic            busy_q;
    logic            done_q;

    logic [PX_W-1:0] w_px;
    logic [PY_W-1:0] w_py;
    logic            w_last;
    logic            w_load;
    logic            w_en;
    logic [8:0]      w_sx;
    logic [7:0]      w_sy;
    logic            w_on;

    assign w_load = (state_q == IDLE) && go;
    assign w_en   = (state_q == DRAW);

    square_scan_counter #(
        .PX_W    (PX_W),
        .PY_W    (PY_W),
        .PY_LAST (SQ_SIZE - 1)
    ) u_scan (
        .clk      (clk),
        .reset    (reset),
        .load_i   (w_load),
        .en_i     (w_en),
        .px_lim_i (lim_q),
        .px_o     (w_px),
        .py_o     (w_py),
        .last_o   (w_last)
    );

    // One extra bit so right/bottom overflow is detectable rather than wrapping
    assign w_sx = {1'b0, bx_q} + 9'(w_px);
    assign w_sy = {1'b0, by_q} + 8'(w_py);
    assign w_on = (w_sx < 9'(SCREEN_W)) && (w_sy < 8'(SCREEN_H));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bx_q      <= '0;
            by_q      <= '0;
            col_q     <= '0;
            lim_q     <= '0;
            vga_x_q   <= '0;
            vga_y_q   <= '0;
            vga_col_q <= '0;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    plot_q <= 1'b0;
                    done_q <= 1'b0;
                    if (go) begin
                        bx_q    <= x_in;
                        by_q    <= y_in;
                        col_q   <= colour_in;
                        lim_q   <= px_limit(clamp_len(len_in));
                        busy_q  <= 1'b1;
                        state_q <= DRAW;
                    end
                end
                DRAW: begin
                    vga_x_q   <= w_sx[7:0];
                    vga_y_q   <= w_sy[6:0];
                    vga_col_q <= col_q;
                    plot_q    <= w_on;
                    if (w_last) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    plot_q  <= 1'b0;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    plot_q  <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_col_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_block_plotter.sv
`default_nettype none
// ============================================================================
// tb_block_plotter : directed vector bench for block_plotter
// Rev 1.0
// ============================================================================
module tb_block_plotter;

    logic       clk;
    logic       reset;
    logic       go;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic [2:0] colour_in;
    logic [2:0] len_in;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic       busy;
    logic       done;

    int n_total = 0;
    int n_pass  = 0;

    block_plotter dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .x_in       (x_in),
        .y_in       (y_in),
        .colour_in  (colour_in),
        .len_in     (len_in),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int col;
        int len;
        int nplots;
        int fx;
        int fy;
        int lx;
        int ly;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issues one row and checks the full pixel stream against the geometric model
    task automatic run_row(input vec_t v);
        int eff_len, w, n, idx, p, ex, ey;
        int plots, fx, fy, lx, ly, bad, done_idx;
        logic [7:0] ex8;
        logic [6:0] ey7;
        logic on;
        eff_len  = (v.len == 0) ? 1 : ((v.len > 4) ? 4 : v.len);
        w        = eff_len * 4;
        n        = w * 4;
        plots    = 0; fx = -1; fy = -1; lx = -1; ly = -1;
        bad      = 0;
        done_idx = -1;
        idx      = 0;
        @(negedge clk);
        x_in      = 8'(v.x);
        y_in      = 7'(v.y);
        colour_in = 3'(v.col);
        len_in    = 3'(v.len);
        go        = 1'b1;
        while (idx < 200 && done_idx < 0) begin
            @(posedge clk);
            #1;
            idx++;
            if (idx == 1) begin
                go        = 1'b0;
                x_in      = 8'hAA;
                y_in      = 7'h55;
                colour_in = 3'd5;
                len_in    = 3'd2;
            end
            if (plot && done) bad++;
            if (idx >= 2 && idx <= n + 1) begin
                p   = idx - 2;
                ex  = v.x + (p % w);
                ey  = v.y + (p / w);
                ex8 = ex[7:0];
                ey7 = ey[6:0];
                on  = (ex < 160) && (ey < 120);
                if (vga_x != ex8 || vga_y != ey7 || vga_colour != 3'(v.col) || plot != on || !busy)
                    bad++;
            end else if (plot) begin
                bad++;
            end
            if (plot) begin
                if (plots == 0) begin fx = int'(vga_x); fy = int'(vga_y); end
                lx = int'(vga_x);
                ly = int'(vga_y);
                plots++;
            end
            if (done) done_idx = idx;
        end
        check("plot_count", plots, v.nplots);
        check("first_x", fx, v.fx);
        check("first_y", fy, v.fy);
        check("last_x", lx, v.lx);
        check("last_y", ly, v.ly);
        check("done_cycle", done_idx, n + 2);
        check("pixel_stream_errors", bad, 0);
        @(posedge clk);
        #1;
        check("done_one_cycle_busy_idle", {30'd0, done, busy}, 0);
    endtask

    initial begin
        int dones, plots;
        reset     = 1'b0;
        go        = 1'b0;
        x_in      = '0;
        y_in      = '0;
        colour_in = '0;
        len_in    = '0;

        vecs[0] = '{x:8,   y:116, col:6, len:1, nplots:16, fx:8,   fy:116, lx:11,  ly:119};
        vecs[1] = '{x:152, y:0,   col:1, len:3, nplots:32, fx:152, fy:0,   lx:159, ly:3};
        vecs[2] = '{x:20,  y:10,  col:2, len:0, nplots:16, fx:20,  fy:10,  lx:23,  ly:13};
        vecs[3] = '{x:0,   y:0,   col:7, len:7, nplots:64, fx:0,   fy:0,   lx:15,  ly:3};
        vecs[4] = '{x:0,   y:116, col:0, len:2, nplots:32, fx:0,   fy:116, lx:7,   ly:119};
        vecs[5] = '{x:40,  y:118, col:5, len:1, nplots:8,  fx:40,  fy:118, lx:43,  ly:119};

        repeat (3) @(posedge clk);
        #1;
        check("reset_vga_x", int'(vga_x), 0);
        check("reset_vga_y", int'(vga_y), 0);
        check("reset_colour", int'(vga_colour), 0);
        check("reset_flags", {29'd0, plot, busy, done}, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_row(vecs[i]);
        end

        // go re-pulsed mid-DRAW and in the DONE cycle must not start another row
        dones = 0;
        plots = 0;
        x_in = 8'd30; y_in = 7'd30; colour_in = 3'd3; len_in = 3'd1;
        for (int e = 0; e < 45; e++) begin
            @(negedge clk);
            go = (e == 0 || e == 5 || e == 17);
            @(posedge clk);
            #1;
            if (plot) plots++;
            if (done) dones++;
        end
        go = 1'b0;
        check("repulse_done_count", dones, 1);
        check("repulse_plot_count", plots, 16);
        check("repulse_idle_busy", int'(busy), 0);

        // asynchronous reset partway through a row
        plots = 0;
        @(negedge clk);
        x_in = 8'd50; y_in = 7'd50; colour_in = 3'd4; len_in = 3'd1;
        go = 1'b1;
        for (int e = 0; e < 40 && plots < 5; e++) begin
            @(posedge clk);
            #1;
            go = 1'b0;
            if (plot) plots++;
        end
        check("pre_reset_plots", plots, 5);
        #2;
        reset = 1'b0;
        #1;
        check("reset_drops_plot", int'(plot), 0);
        check("reset_drops_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        dones = 0;
        plots = 0;
        for (int e = 0; e < 25; e++) begin
            @(posedge clk);
            #1;
            if (plot) plots++;
            if (done) dones++;
        end
        check("post_reset_no_activity", plots + dones, 0);
        run_row('{x:60, y:20, col:6, len:1, nplots:16, fx:60, fy:20, lx:63, ly:23});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
